// File: rtl/disp_pkg.sv
// Shared types and helpers for the display sharing controller.
//   state_e    : controller FSM states
//   SEG_*      : active-low segment patterns (bit0 = a .. bit6 = g)
//   CONV_STEPS : number of shift-add-3 iterations for a 7-bit magnitude
//   seg_of()   : BCD nibble to active-low 7-segment pattern
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        UPD,
        HOLD
    } state_e;

    localparam logic [6:0]  SEG_BLANK  = 7'b1111111;
    localparam logic [6:0]  SEG_MINUS  = 7'b0111111;
    localparam int unsigned CONV_STEPS = 7;

    function automatic logic [6:0] seg_of(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seq_bin2bcd.sv
// Iterative 7-bit binary to BCD converter (shift-add-3, one bit per cycle).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start_i      : load bin_i, clear the BCD digits and step counter
//   bin_i        : 7-bit unsigned value to convert
//   done_o       : high during the last conversion step; results valid on the next cycle
//   ones_o       : BCD ones digit
//   tens_o       : BCD tens digit
//   hundreds_o   : BCD hundreds digit (0..1 for a 7-bit input)
module seq_bin2bcd
    import disp_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [6:0] bin_i,
    output logic       done_o,
    output logic [3:0] ones_o,
    output logic [3:0] tens_o,
    output logic [1:0] hundreds_o
);

    localparam logic [2:0] LastStep = 3'(CONV_STEPS - 1);

    logic [6:0] bin_q;
    logic [3:0] ones_q;
    logic [3:0] tens_q;
    logic [1:0] hund_q;
    logic [2:0] cnt_q;
    logic       run_q;

    logic [3:0] ones_adj;
    logic [3:0] tens_adj;

    // Hundreds never reaches 5 for a 7-bit input, so it needs no correction.
    always_comb begin
        ones_adj = (ones_q >= 4'd5) ? 4'(ones_q + 4'd3) : ones_q;
        tens_adj = (tens_q >= 4'd5) ? 4'(tens_q + 4'd3) : tens_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            ones_q <= '0;
            tens_q <= '0;
            hund_q <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
        end else if (start_i) begin
            bin_q  <= bin_i;
            ones_q <= '0;
            tens_q <= '0;
            hund_q <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b1;
        end else if (run_q) begin
            // Shift {hundreds, tens, ones, bin} left by one after correction.
            hund_q <= {hund_q[0], tens_adj[3]};
            tens_q <= {tens_adj[2:0], ones_adj[3]};
            ones_q <= {ones_adj[2:0], bin_q[6]};
            bin_q  <= {bin_q[5:0], 1'b0};
            cnt_q  <= 3'(cnt_q + 3'd1);
            if (cnt_q == LastStep) begin
                run_q <= 1'b0;
            end
        end
    end

    assign done_o     = run_q && (cnt_q == LastStep);
    assign ones_o     = ones_q;
    assign tens_o     = tens_q;
    assign hundreds_o = hund_q;

endmodule

// File: rtl/disp_share_ctrl.sv
// Display controller shared by two result producers. Arbitrates round-robin,
// converts the granted signed-magnitude byte to BCD and drives four registered
// active-low 7-segment digits, with optional leading-zero blanking and a
// minimum hold time before the next grant.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   req[1:0]     : level request per producer, held until its ack
//   data0, data1 : producer values, bit7 = sign, bits 6:0 = magnitude
//   ack[1:0]     : one-cycle pulse when that producer's value is on display
//   busy         : high whenever the controller is not idle
//   sel          : producer whose value is displayed
//   valid        : high once anything has been displayed since reset
//   hex0..hex2   : ones, tens, hundreds digits
//   hex3         : sign digit (minus or blank)
module disp_share_ctrl
    import disp_pkg::*;
#(
    parameter bit          BLANK_LZ    = 1'b1,
    parameter int unsigned HOLD_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic [1:0] ack,
    output logic       busy,
    output logic       sel,
    output logic       valid,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3
);

    // Unreachable when HOLD_CYCLES is 0 (HOLD is skipped entirely).
    localparam logic [7:0] HoldLast = 8'(HOLD_CYCLES - 1);

    state_e     state_q;
    logic       rr_q;      // preferred requester when both are asking
    logic       gnt_q;
    logic [7:0] data_q;
    logic [7:0] hold_cnt_q;
    logic [1:0] ack_q;
    logic       busy_q;
    logic       sel_q;
    logic       valid_q;
    logic [6:0] hex0_q;
    logic [6:0] hex1_q;
    logic [6:0] hex2_q;
    logic [6:0] hex3_q;

    logic       gnt_idx;
    logic       start;
    logic [7:0] gnt_data;
    logic       conv_done;
    logic [3:0] bcd_ones;
    logic [3:0] bcd_tens;
    logic [1:0] bcd_hund;
    logic [6:0] seg_h0;
    logic [6:0] seg_h1;
    logic [6:0] seg_h2;
    logic [6:0] seg_h3;

    // Arbitration.
    always_comb begin
        gnt_idx = 1'b0;
        unique case (req)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = rr_q;
            default: gnt_idx = 1'b0;
        endcase
    end

    assign start    = (state_q == IDLE) && (req != 2'b00);
    assign gnt_data = gnt_idx ? data1 : data0;

    seq_bin2bcd u_bin2bcd (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .bin_i      (gnt_data[6:0]),
        .done_o     (conv_done),
        .ones_o     (bcd_ones),
        .tens_o     (bcd_tens),
        .hundreds_o (bcd_hund)
    );

    // Segment patterns for the converted value; registered only in UPD.
    always_comb begin
        seg_h0 = seg_of(bcd_ones);
        seg_h1 = seg_of(bcd_tens);
        seg_h2 = seg_of({2'b00, bcd_hund});
        seg_h3 = SEG_BLANK;
        // Negative zero shows no minus sign.
        if (data_q[7] && (data_q[6:0] != 7'd0)) begin
            seg_h3 = SEG_MINUS;
        end
        if (BLANK_LZ && (bcd_hund == 2'd0)) begin
            seg_h2 = SEG_BLANK;
            if (bcd_tens == 4'd0) begin
                seg_h1 = SEG_BLANK;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_q       <= 1'b0;
            gnt_q      <= 1'b0;
            data_q     <= '0;
            hold_cnt_q <= '0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
            sel_q      <= 1'b0;
            valid_q    <= 1'b0;
            hex0_q     <= SEG_BLANK;
            hex1_q     <= SEG_BLANK;
            hex2_q     <= SEG_BLANK;
            hex3_q     <= SEG_BLANK;
        end else begin
            ack_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        gnt_q   <= gnt_idx;
                        data_q  <= gnt_data;
                        rr_q    <= ~gnt_idx;
                        state_q <= CONV;
                        busy_q  <= 1'b1;
                    end
                end
                CONV: begin
                    if (conv_done) begin
                        state_q <= UPD;
                    end
                end
                UPD: begin
                    hex0_q     <= seg_h0;
                    hex1_q     <= seg_h1;
                    hex2_q     <= seg_h2;
                    hex3_q     <= seg_h3;
                    sel_q      <= gnt_q;
                    valid_q    <= 1'b1;
                    ack_q      <= gnt_q ? 2'b10 : 2'b01;
                    hold_cnt_q <= '0;
                    if (HOLD_CYCLES == 0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (hold_cnt_q == HoldLast) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        hold_cnt_q <= 8'(hold_cnt_q + 8'd1);
                    end
                end
            endcase
        end
    end

    assign ack   = ack_q;
    assign busy  = busy_q;
    assign sel   = sel_q;
    assign valid = valid_q;
    assign hex0  = hex0_q;
    assign hex1  = hex1_q;
    assign hex2  = hex2_q;
    assign hex3  = hex3_q;

endmodule

// File: tb/tb_disp_share_ctrl.sv
// Bench for disp_share_ctrl: instance A (blanking on, no hold) and
// instance B (blanking off, hold of 4 cycles). Expected displays are queued
// when a request is driven and checked when the DUT pulses ack.
module tb_disp_share_ctrl;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [6:0] SM = 7'b0111111;

    typedef struct {
        logic [1:0] req;
        logic [7:0] data;
        logic       drop;
        logic [6:0] h3, h2, h1, h0;
    } vec_t;

    typedef struct {
        logic [1:0] ack;
        logic       sel;
        logic [6:0] h3, h2, h1, h0;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    vec_t vecs[8];

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req_a = 2'b00, req_b = 2'b00;
    logic [7:0] d0_a = 8'h00, d1_a = 8'h00, d0_b = 8'h00, d1_b = 8'h00;

    logic [1:0] ack_a, ack_b;
    logic       busy_a, busy_b, sel_a, sel_b, valid_a, valid_b;
    logic [6:0] h0_a, h1_a, h2_a, h3_a, h0_b, h1_b, h2_b, h3_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    disp_share_ctrl #(.BLANK_LZ(1'b1), .HOLD_CYCLES(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .data0(d0_a), .data1(d1_a),
        .ack(ack_a), .busy(busy_a), .sel(sel_a), .valid(valid_a),
        .hex0(h0_a), .hex1(h1_a), .hex2(h2_a), .hex3(h3_a)
    );

    disp_share_ctrl #(.BLANK_LZ(1'b0), .HOLD_CYCLES(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .data0(d0_b), .data1(d1_b),
        .ack(ack_b), .busy(busy_b), .sel(sel_b), .valid(valid_b),
        .hex0(h0_b), .hex1(h1_b), .hex2(h2_b), .hex3(h3_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_disp(input string p, input exp_t e, input logic [1:0] ack,
                              input logic sel, input logic valid, input logic [6:0] h3,
                              input logic [6:0] h2, input logic [6:0] h1, input logic [6:0] h0);
        chk({p, "_ack"}, 32'(ack), 32'(e.ack));
        chk({p, "_sel"}, 32'(sel), 32'(e.sel));
        chk({p, "_valid"}, 32'(valid), 32'd1);
        chk({p, "_hex"}, {4'h0, h3, h2, h1, h0}, {4'h0, e.h3, e.h2, e.h1, e.h0});
    endtask

    // Scoreboard monitors: every ack must match the oldest queued expectation.
    always @(negedge clk) begin
        if (ack_a !== 2'b00) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_ack", 32'(ack_a), 32'd0);
            end else begin
                ea = q_a.pop_front();
                check_disp("a", ea, ack_a, sel_a, valid_a, h3_a, h2_a, h1_a, h0_a);
            end
        end
    end

    always @(negedge clk) begin
        if (ack_b !== 2'b00) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_ack", 32'(ack_b), 32'd0);
            end else begin
                eb = q_b.pop_front();
                check_disp("b", eb, ack_b, sel_b, valid_b, h3_b, h2_b, h1_b, h0_b);
            end
        end
    end

    // Drive one request on instance A (which=0) or B (which=1); wait for its ack.
    task automatic run(input bit which, input vec_t v);
        exp_t e;
        int   k;
        bit   seen;
        e.ack = v.req;
        e.sel = v.req[1];
        e.h3  = v.h3;
        e.h2  = v.h2;
        e.h1  = v.h1;
        e.h0  = v.h0;
        if (which) begin
            q_b.push_back(e);
            if (v.req[1]) d1_b = v.data; else d0_b = v.data;
            req_b = v.req;
        end else begin
            q_a.push_back(e);
            if (v.req[1]) d1_a = v.data; else d0_a = v.data;
            req_a = v.req;
        end
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            // The value latched at the grant edge must be the one displayed.
            if (k == 1) begin
                if (which) begin d0_b = ~d0_b; d1_b = ~d1_b; end
                else       begin d0_a = ~d0_a; d1_a = ~d1_a; end
            end
            if (v.drop && k == 3) begin
                if (which) req_b = 2'b00; else req_a = 2'b00;
            end
            if ((which ? ack_b : ack_a) !== 2'b00) seen = 1'b1;
        end
        chk(which ? "b_latency" : "a_latency", k, 9);
        if (which) req_b = 2'b00; else req_a = 2'b00;
        @(negedge clk);
        chk(which ? "b_ack_pulse" : "a_ack_pulse", 32'(which ? ack_b : ack_a), 32'd0);
        chk(which ? "b_busy_after" : "a_busy_after", 32'(which ? busy_b : busy_a),
            which ? 32'd1 : 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   k, nack, last, lowcnt;

        vecs[0] = '{req: 2'b01, data: 8'h7F, drop: 1'b0, h3: SB, h2: S1, h1: S2, h0: S7};
        vecs[1] = '{req: 2'b10, data: 8'h85, drop: 1'b0, h3: SM, h2: SB, h1: SB, h0: S5};
        vecs[2] = '{req: 2'b01, data: 8'h80, drop: 1'b0, h3: SB, h2: SB, h1: SB, h0: S0};
        vecs[3] = '{req: 2'b01, data: 8'h64, drop: 1'b0, h3: SB, h2: S1, h1: S0, h0: S0};
        vecs[4] = '{req: 2'b10, data: 8'h0A, drop: 1'b0, h3: SB, h2: SB, h1: S1, h0: S0};
        vecs[5] = '{req: 2'b01, data: 8'hC2, drop: 1'b1, h3: SM, h2: SB, h1: S6, h0: S6};
        vecs[6] = '{req: 2'b10, data: 8'h09, drop: 1'b0, h3: SB, h2: SB, h1: SB, h0: S9};
        vecs[7] = '{req: 2'b01, data: 8'h5F, drop: 1'b1, h3: SB, h2: SB, h1: S9, h0: S5};

        // Reset and idle: outputs stay at reset values.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("rst_hex", {4'h0, h3_a, h2_a, h1_a, h0_a}, {4'h0, SB, SB, SB, SB});
            chk("rst_status", {27'd0, ack_a, busy_a, valid_a, sel_a}, 32'd0);
        end

        // Table vectors on instance A.
        for (int i = 0; i < 8; i++) begin
            run(1'b0, vecs[i]);
        end

        // Instance B without blanking.
        v = '{req: 2'b10, data: 8'h85, drop: 1'b0, h3: SM, h2: S0, h1: S0, h0: S5};
        run(1'b1, v);

        // Both requesting continuously with a 4-cycle hold: alternate, 13 cycles apart.
        d0_b = 8'h12;
        d1_b = 8'h83;
        for (int i = 0; i < 2; i++) begin
            q_b.push_back('{ack: 2'b01, sel: 1'b0, h3: SB, h2: S0, h1: S1, h0: S8});
            q_b.push_back('{ack: 2'b10, sel: 1'b1, h3: SM, h2: S0, h1: S0, h0: S3});
        end
        req_b  = 2'b11;
        k      = 0;
        nack   = 0;
        last   = 0;
        lowcnt = 0;
        while (nack < 4 && k < 200) begin
            @(negedge clk);
            k++;
            if (ack_b !== 2'b00) begin
                if (nack > 0) begin
                    chk("b_interval", k - last, 13);
                    chk("b_idle_gap", lowcnt, 1);
                end
                last   = k;
                lowcnt = 0;
                nack++;
            end else if (!busy_b) begin
                lowcnt++;
            end
        end
        chk("b_ack_count", nack, 4);
        req_b = 2'b00;
        repeat (8) @(negedge clk);

        // Reset in the middle of a conversion on instance A.
        d1_a  = 8'h33;
        req_a = 2'b10;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_hex", {4'h0, h3_a, h2_a, h1_a, h0_a}, {4'h0, SB, SB, SB, SB});
        chk("abort_status", {27'd0, ack_a, busy_a, valid_a, sel_a}, 32'd0);
        repeat (2) @(negedge clk);
        chk("abort_hold_ack", 32'(ack_a), 32'd0);
        rst_n = 1'b1;
        q_a.push_back('{ack: 2'b10, sel: 1'b1, h3: SB, h2: SB, h1: S5, h0: S1});
        k = 0;
        while (ack_a === 2'b00 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("abort_latency", k, 9);
        req_a = 2'b00;
        repeat (4) @(negedge clk);

        chk("a_queue_empty", q_a.size(), 0);
        chk("b_queue_empty", q_b.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
